// File: rtl/ddp_pkt_fifo.sv
// Register-array FIFO for 267-bit DDP packet words between the assembler and the cut/pad stage.
// Status flags decode from a registered occupancy count, so they always describe the start of the cycle.
module ddp_pkt_fifo #(
  parameter int DEPTH       = 16,
  parameter int AFULL_LEVEL = 12,
  localparam int W  = 267,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ddpPktPush,
  input  logic [W-1:0]  ddpPktDataIn,
  input  logic          ddpPktPop,
  output logic [W-1:0]  ddpPktDataOut,
  output logic          ddpPktDataValid,
  output logic          ddpPktFull,
  output logic          ddpPktEmpty,
  output logic          ddpPktAlmostFull,
  output logic [LW-1:0] ddpPktLevel,
  output logic          ddpPktOvfl,
  output logic          ddpPktUdfl,
  input  logic          errClear
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push_ok, pop_ok;

  assign ddpPktFull       = (ddpPktLevel == LW'(DEPTH));
  assign ddpPktEmpty      = (ddpPktLevel == '0);
  assign ddpPktAlmostFull = (ddpPktLevel >= LW'(AFULL_LEVEL));

  // Full/empty are pre-cycle, so a push+pop on full drops the push and on empty drops the pop.
  assign push_ok = ddpPktPush && !ddpPktFull;
  assign pop_ok  = ddpPktPop  && !ddpPktEmpty;

  // Storage is intentionally not reset.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= ddpPktDataIn;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ddpPktLevel <= '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10:   ddpPktLevel <= ddpPktLevel + 1'b1;
        2'b01:   ddpPktLevel <= ddpPktLevel - 1'b1;
        default: ddpPktLevel <= ddpPktLevel;
      endcase
    end
  end

  // Read data holds between accepted pops; valid marks the cycle after each one.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ddpPktDataOut   <= '0;
      ddpPktDataValid <= 1'b0;
    end else begin
      ddpPktDataValid <= pop_ok;
      if (pop_ok) ddpPktDataOut <= mem[rd_ptr];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ddpPktOvfl <= 1'b0;
      ddpPktUdfl <= 1'b0;
    end else if (errClear) begin
      ddpPktOvfl <= 1'b0;
      ddpPktUdfl <= 1'b0;
    end else begin
      if (ddpPktPush && ddpPktFull)  ddpPktOvfl <= 1'b1;
      if (ddpPktPop  && ddpPktEmpty) ddpPktUdfl <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ddp_pkt_fifo.sv
// Random and directed stimulus for ddp_pkt_fifo, checked every cycle against a queue-based model.
module tb_ddp_pkt_fifo;
  localparam int DEPTH = 16;
  localparam int AFULL = 12;
  localparam int W     = 267;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         push = 1'b0, pop = 1'b0, clr = 1'b0;
  logic [W-1:0] din = '0;
  logic [W-1:0] dout;
  logic         dvalid, full, empty, afull, ovfl, udfl;
  logic [4:0]   level;

  int chk  = 0;
  int pass = 0;

  ddp_pkt_fifo #(.DEPTH(DEPTH), .AFULL_LEVEL(AFULL)) dut (
    .clock(clock), .reset(reset),
    .ddpPktPush(push), .ddpPktDataIn(din), .ddpPktPop(pop),
    .ddpPktDataOut(dout), .ddpPktDataValid(dvalid),
    .ddpPktFull(full), .ddpPktEmpty(empty), .ddpPktAlmostFull(afull),
    .ddpPktLevel(level), .ddpPktOvfl(ovfl), .ddpPktUdfl(udfl),
    .errClear(clr)
  );

  always #5 clock = ~clock;

  // Behavioural model: a queue of words plus the last popped word and sticky flags.
  logic [W-1:0] q[$];
  logic [W-1:0] m_dout;
  logic         m_valid, m_ovfl, m_udfl;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      q.delete();
      m_dout  = '0;
      m_valid = 1'b0;
      m_ovfl  = 1'b0;
      m_udfl  = 1'b0;
    end else begin
      int n;
      n = q.size();
      m_valid = 1'b0;
      if (pop && n > 0) begin
        m_dout  = q.pop_front();
        m_valid = 1'b1;
      end
      if (push && n < DEPTH) q.push_back(din);
      if (clr) begin
        m_ovfl = 1'b0;
        m_udfl = 1'b0;
      end else begin
        if (push && n == DEPTH) m_ovfl = 1'b1;
        if (pop && n == 0)      m_udfl = 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    else pass++;
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      int n;
      n = q.size();
      check("level", W'(level), W'(n));
      check("full",  W'(full),  W'(n == DEPTH));
      check("empty", W'(empty), W'(n == 0));
      check("afull", W'(afull), W'(n >= AFULL));
      check("ovfl",  W'(ovfl),  W'(m_ovfl));
      check("udfl",  W'(udfl),  W'(m_udfl));
      check("valid", W'(dvalid), W'(m_valid));
      check("dout",  dout, m_dout);
    end
  end

  function automatic logic [W-1:0] rand_word();
    logic [287:0] t;
    for (int i = 0; i < 9; i++) t[i*32 +: 32] = $urandom;
    return t[W-1:0];
  endfunction

  // Called at a falling edge: drive inputs, then wait one full cycle.
  task automatic step(input logic p, input logic r, input logic [W-1:0] d, input logic c);
    push = p; pop = r; din = d; clr = c;
    @(negedge clock);
    push = 1'b0; pop = 1'b0; clr = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clock);
    check("rst_level", W'(level), '0);
    check("rst_empty", W'(empty), W'(1));
    check("rst_full",  W'(full),  '0);
    check("rst_valid", W'(dvalid), '0);
    check("rst_dout",  dout, '0);
    check("rst_flags", W'({ovfl, udfl, afull}), '0);
    #1 reset = 1'b0;
    @(negedge clock);

    // Fill and drain
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 1'b0, W'(i), 1'b0);
      if (i == 10) check("afull_below", W'(afull), '0);
      if (i == 11) check("afull_at12",  W'(afull), W'(1));
      if (i == 14) check("full_at15",   W'(full),  '0);
    end
    check("fill_level", W'(level), W'(16));
    check("fill_full",  W'(full),  W'(1));
    step(1'b1, 1'b0, W'(99), 1'b0);
    check("push_full_level", W'(level), W'(16));
    check("push_full_ovfl",  W'(ovfl),  W'(1));
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b1, '0, 1'b0);
      check("drain_valid", W'(dvalid), W'(1));
      check("drain_data",  dout, W'(i));
    end
    check("drain_empty", W'(empty), W'(1));

    // Pop on empty, then clear
    step(1'b0, 1'b1, '0, 1'b0);
    check("udfl_valid", W'(dvalid), '0);
    check("udfl_dout",  dout, W'(15));
    check("udfl_set",   W'(udfl), W'(1));
    step(1'b0, 1'b0, '0, 1'b1);
    check("clr_flags", W'({ovfl, udfl}), '0);

    // Simultaneous push/pop at level 5, wrapping the pointers
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, rand_word(), 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1, rand_word(), 1'b0);
    check("steady_level", W'(level), W'(5));

    // Simultaneous push/pop when full
    for (int i = 0; i < 11; i++) step(1'b1, 1'b0, rand_word(), 1'b0);
    step(1'b1, 1'b1, rand_word(), 1'b0);
    check("pp_full_level", W'(level), W'(15));
    check("pp_full_ovfl",  W'(ovfl),  W'(1));
    step(1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, '0, 1'b0);

    // Simultaneous push/pop when empty
    step(1'b1, 1'b1, W'(7), 1'b0);
    check("pp_empty_level", W'(level), W'(1));
    check("pp_empty_udfl",  W'(udfl),  W'(1));
    check("pp_empty_valid", W'(dvalid), '0);

    // Random traffic, including error clears landing on error cycles
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 50),
           rand_word(), ($urandom_range(0, 99) < 5));

    // Mid-stream reset at level 9 during a pop
    while (q.size() > 0) step(1'b0, 1'b1, '0, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, rand_word(), 1'b0);
    check("pre_rst_level", W'(level), W'(9));
    pop = 1'b1;
    @(posedge clock);
    #2;
    check("inflight_valid", W'(dvalid), W'(1));
    reset = 1'b1;
    #1;
    check("async_rst_valid", W'(dvalid), '0);
    check("async_rst_level", W'(level), '0);
    check("async_rst_empty", W'(empty), W'(1));
    pop = 1'b0;
    @(negedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    step(1'b1, 1'b0, W'(16'h1A5), 1'b0);
    step(1'b0, 1'b1, '0, 1'b0);
    check("post_rst_valid", W'(dvalid), W'(1));
    check("post_rst_data",  dout, W'(16'h1A5));
    step(1'b0, 1'b0, '0, 1'b0);

    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

endmodule
